// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encoding and limits for mult_arbiter
package mult_arb_pkg;

  localparam int MULT_ARB_MAX_NREQ = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOADB,
    START,
    WAITB,
    RUN,
    RESP
  } mult_arb_state_t;

  function automatic int next_idx(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational one-hot grant picker searching upward from ptr
// A pointer held at zero reduces the search to lowest-index-wins fixed priority.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] j;

  // Walk from the farthest offset down so the requester nearest ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - shares one shift-add signed multiplier core among NREQ requesters
// MULT_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [2*W-1:0]      resp_data,
  output logic [W-1:0]        mul_s,
  output logic                mul_ldb,
  output logic                mul_run,
  input  logic                mul_busy,
  input  logic [2*W-1:0]      mul_prod
);

  localparam int IW = $clog2(NREQ);

  generate
    if (NREQ < 2 || NREQ > MULT_ARB_MAX_NREQ) begin : g_bad_nreq
      $error("mult_arbiter: NREQ out of range");
    end
  endgenerate

  mult_arb_state_t state, state_n;
  logic [W-1:0]     a_q, b_q;
  logic [2*W-1:0]   result_q;
  logic [IW-1:0]    g_q;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    pick_idx;
  logic [NREQ-1:0]  pick_grant;
  logic             accept;
  logic             resp_done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign accept    = (state == IDLE) && (|req_valid);
  assign resp_done = (state == RESP) && resp_ready[g_q];
  assign resp_data = result_q;

`ifdef MULT_ARB_RR_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr <= '0;
    end else if (resp_done) begin
      ptr <= IW'(next_idx(int'(g_q), NREQ));
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = '0;
    resp_valid = '0;
    mul_s      = '0;
    mul_ldb    = 1'b0;
    mul_run    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = pick_grant;
        if (accept) state_n = LOADB;
      end
      LOADB: begin
        mul_s   = b_q;
        mul_ldb = 1'b1;
        state_n = START;
      end
      START: begin
        mul_s   = a_q;
        mul_run = 1'b1;
        state_n = WAITB;
      end
      // A busy left high from an earlier operation is taken as this run's busy.
      WAITB: begin
        mul_s = a_q;
        if (mul_busy) state_n = RUN;
      end
      RUN: begin
        mul_s = a_q;
        if (!mul_busy) state_n = RESP;
      end
      RESP: begin
        resp_valid[g_q] = 1'b1;
        if (resp_ready[g_q]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      g_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        a_q <= req_a[int'(pick_idx)*W +: W];
        b_q <= req_b[int'(pick_idx)*W +: W];
        g_q <= pick_idx;
      end
      if (state == RUN && !mul_busy) begin
        result_q <= mul_prod;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed scoreboard bench for mult_arbiter with a behavioural core
module tb_mult_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [2*W-1:0]    resp_data;
  logic [W-1:0]      mul_s;
  logic              mul_ldb;
  logic              mul_run;
  logic              mul_busy;
  logic [2*W-1:0]    mul_prod;

  mult_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .mul_s      (mul_s),
    .mul_ldb    (mul_ldb),
    .mul_run    (mul_run),
    .mul_busy   (mul_busy),
    .mul_prod   (mul_prod)
  );

  always #5 Clk = ~Clk;

  // Core model: busy rises delay_cfg cycles after run, lasts busy_len cycles.
  int          delay_cfg = 1;
  int          busy_len  = 4;
  int          cnt       = 0;
  int          run_count = 0;
  logic [7:0]  core_b    = '0;
  logic [15:0] core_prod = '0;

  assign mul_busy = (cnt > 0) && (cnt <= busy_len);
  assign mul_prod = (cnt == 0) ? core_prod : 16'hDEAD;

  always @(posedge Clk) begin
    if (Reset) begin
      cnt <= 0;
    end else begin
      if (mul_ldb) core_b <= mul_s;
      if (mul_run) begin
        core_prod <= {{8{mul_s[7]}}, mul_s} * {{8{core_b[7]}}, core_b};
        cnt       <= delay_cfg - 1 + busy_len;
        run_count <= run_count + 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge, dropping valid for any requester accepted on the way.
  task automatic step();
    logic [NREQ-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(negedge Clk);
    req_valid = req_valid & ~acc;
  endtask

  task automatic push(input int idx, input logic [15:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_resp(input int hold, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (resp_valid == '0 && lat < 60) begin
      step();
      lat++;
    end
    checks++;
    assert (resp_valid != '0) else begin
      errors++;
      $error("FAIL resp_timeout: observed resp_valid 0x%0h after %0d cycles expected nonzero", resp_valid, lat);
      return;
    end
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty: observed resp_valid 0x%0h expected no response", resp_valid);
      return;
    end
    e = sb.pop_front();
    if (exp_lat >= 0) chk("resp_latency", lat, exp_lat);
    chk("resp_valid", resp_valid, 32'(1 << e.idx));
    chk("resp_data", resp_data, e.data);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_valid", resp_valid, 32'(1 << e.idx));
      chk("bp_data", resp_data, e.data);
      chk("bp_req_ready", req_ready, 0);
    end
    resp_ready = NREQ'(1 << e.idx);
    step();
    resp_ready = '0;
    chk("resp_drop", resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int  rc0;
    logic seen;
    Reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mul_ldb", mul_ldb, 0);
    chk("rst_mul_run", mul_run, 0);
    chk("rst_mul_s", mul_s, 0);
    chk("rst_resp_data", resp_data, 0);

    // Simultaneous pair with pointer at 0: requester 0 first either way.
    req_a     = {8'h80, 8'h05};
    req_b     = {8'h80, 8'h07};
    req_valid = 2'b11;
    #1;
    chk("pair1_ready", req_ready, 2'b01);
    push(0, 16'h0023);
    push(1, 16'h4000);
    wait_resp(0, -1);
    wait_resp(0, -1);
    chk("pair1_drained", req_valid, 0);

    // Single request with operand routing and latency checks.
    req_a     = {8'h00, 8'h03};
    req_b     = {8'h00, 8'hFE};
    req_valid = 2'b01;
    #1;
    chk("single_ready", req_ready, 2'b01);
    push(0, 16'hFFFA);
    step();
    chk("c1_mul_ldb", mul_ldb, 1);
    chk("c1_mul_s", mul_s, 8'hFE);
    chk("c1_mul_run", mul_run, 0);
    step();
    chk("c2_mul_run", mul_run, 1);
    chk("c2_mul_s", mul_s, 8'h03);
    chk("c2_mul_ldb", mul_ldb, 0);
    wait_resp(0, 6);

    // Second simultaneous pair: round-robin now favours requester 1.
    req_a     = {8'h7F, 8'hFF};
    req_b     = {8'h80, 8'h01};
    req_valid = 2'b11;
    #1;
`ifdef MULT_ARB_RR_EN
    chk("pair2_ready", req_ready, 2'b10);
    push(1, 16'hC080);
    push(0, 16'hFFFF);
`else
    chk("pair2_ready", req_ready, 2'b01);
    push(0, 16'hFFFF);
    push(1, 16'hC080);
`endif
    wait_resp(0, -1);
    wait_resp(0, -1);

    // Backpressure with a competing request held off.
    req_a     = {8'hFD, 8'h00};
    req_b     = {8'h09, 8'h00};
    req_valid = 2'b10;
    push(1, 16'hFFE5);
    step();
    req_a[7:0]   = 8'h01;
    req_b[7:0]   = 8'h01;
    req_valid[0] = 1'b1;
    push(0, 16'h0001);
    wait_resp(10, -1);
    chk("bp_idle_ready", req_ready, 2'b01);
    wait_resp(0, -1);

    // Reset during RUN drops the operation.
    req_a     = {8'h00, 8'h04};
    req_b     = {8'h00, 8'h04};
    req_valid = 2'b01;
    repeat (5) step();
    chk("mid_no_resp", resp_valid, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mr_req_ready", req_ready, 0);
    chk("mr_resp_valid", resp_valid, 0);
    chk("mr_mul_ldb", mul_ldb, 0);
    chk("mr_mul_run", mul_run, 0);
    chk("mr_mul_s", mul_s, 0);
    chk("mr_resp_data", resp_data, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (resp_valid != '0) seen = 1'b1;
    end
    chk("mr_no_resp", seen, 0);
    req_a     = {8'h00, 8'h02};
    req_b     = {8'h00, 8'h02};
    req_valid = 2'b01;
    push(0, 16'h0004);
    wait_resp(0, 8);

    // Core raises busy three cycles after run.
    delay_cfg = 3;
    rc0       = run_count;
    req_a     = {8'h06, 8'h00};
    req_b     = {8'hFB, 8'h00};
    req_valid = 2'b10;
    push(1, 16'hFFE2);
    step();
    step();
    chk("db_c2_run", mul_run, 1);
    step();
    chk("db_c3_mul_s", mul_s, 8'h06);
    chk("db_c3_run", mul_run, 0);
    step();
    chk("db_c4_mul_s", mul_s, 8'h06);
    chk("db_c4_run", mul_run, 0);
    wait_resp(0, 6);
    chk("db_run_pulses", run_count - rc0, 1);
    chk("sb_empty_end", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
